// File: rtl/perf_stats.sv
// Performance-statistics unit: saturating event counters plus PC capture,
// with a registered, selector-driven 16-bit view for the LED display block.
module perf_stats #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc,
  input  logic             commit,
  input  logic             is_cbranch,
  input  logic             cbranch_taken,
  input  logic             is_jump,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] stat_value,
  output logic             stat_sat
);

  localparam int N_CNT = 5;
  localparam int I_CYC = 0;
  localparam int I_INS = 1;
  localparam int I_CBR = 2;
  localparam int I_TKN = 3;
  localparam int I_JMP = 4;

  localparam logic [2:0] SEL_PC  = 3'b001;
  localparam logic [2:0] SEL_CYC = 3'b010;
  localparam logic [2:0] SEL_CBR = 3'b011;
  localparam logic [2:0] SEL_TKN = 3'b100;
  localparam logic [2:0] SEL_JMP = 3'b101;
  localparam logic [2:0] SEL_INS = 3'b110;

  logic [CNT_W-1:0] r_cnt [N_CNT];
  logic [N_CNT-1:0] r_sat;
  logic [PC_W-1:0]  r_pc_cap;
  logic [N_CNT-1:0] w_inc;
  logic [CNT_W-1:0] w_value;
  logic             w_sat;

  // A conditional branch that is also flagged as a jump counts as a branch only.
  always_comb begin
    w_inc        = '0;
    w_inc[I_CYC] = ~halt;
    w_inc[I_INS] = commit;
    w_inc[I_CBR] = commit & is_cbranch;
    w_inc[I_TKN] = commit & is_cbranch & cbranch_taken;
    w_inc[I_JMP] = commit & is_jump & ~is_cbranch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so every entry
      // is cleared by reset; a real memory array would not be reset this way.
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
      r_sat    <= '0;
      r_pc_cap <= '0;
    end else if (clear) begin
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
      r_sat    <= '0;
      r_pc_cap <= '0;
    end else begin
      // NOTE: non-blocking assignments make every counter see pre-edge values,
      // so updates are order-independent like real flops.
      for (int i = 0; i < N_CNT; i++) begin
        if (w_inc[i]) begin
          if (r_cnt[i] == '1) r_sat[i] <= 1'b1;
          else                r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      if (commit) r_pc_cap <= pc;
    end
  end

  always_comb begin
    // NOTE: defaults first so no selector value leaves an output unassigned,
    // which would otherwise infer a latch.
    w_value = '0;
    w_sat   = 1'b0;
    case (sel)
      SEL_PC:  w_value = CNT_W'(r_pc_cap);
      SEL_CYC: begin w_value = r_cnt[I_CYC]; w_sat = r_sat[I_CYC]; end
      SEL_CBR: begin w_value = r_cnt[I_CBR]; w_sat = r_sat[I_CBR]; end
      SEL_TKN: begin w_value = r_cnt[I_TKN]; w_sat = r_sat[I_TKN]; end
      SEL_JMP: begin w_value = r_cnt[I_JMP]; w_sat = r_sat[I_JMP]; end
      SEL_INS: begin w_value = r_cnt[I_INS]; w_sat = r_sat[I_INS]; end
      default: ;
    endcase
  end

  // Registered view isolates the display from glitches on the slow sel switch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_value <= '0;
      stat_sat   <= 1'b0;
    end else begin
      stat_value <= w_value;
      stat_sat   <= w_sat;
    end
  end

endmodule

// File: tb/tb_perf_stats.sv
// Self-checking bench for perf_stats: directed scenarios plus randomized
// traffic compared every cycle against an event-counting reference model.
module tb_perf_stats;

  localparam int CNT_W = 16;
  localparam int PC_W  = 12;
  localparam longint MAXV = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic             halt;
  logic [PC_W-1:0]  pc;
  logic             commit;
  logic             is_cbranch;
  logic             cbranch_taken;
  logic             is_jump;
  logic [2:0]       sel;
  logic [CNT_W-1:0] stat_value;
  logic             stat_sat;

  int vectors = 0;
  int errors  = 0;

  // Reference model: plain event tallies clipped at MAXV, plus the visible view.
  longint m_cycles, m_retired, m_branches, m_taken, m_jumps, m_pc;
  bit     s_cycles, s_retired, s_branches, s_taken, s_jumps;
  longint exp_val;
  bit     exp_sat;

  perf_stats #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .halt(halt), .pc(pc),
    .commit(commit), .is_cbranch(is_cbranch), .cbranch_taken(cbranch_taken),
    .is_jump(is_jump), .sel(sel), .stat_value(stat_value), .stat_sat(stat_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_cycles = 0; m_retired = 0; m_branches = 0; m_taken = 0; m_jumps = 0; m_pc = 0;
    s_cycles = 0; s_retired = 0; s_branches = 0; s_taken = 0; s_jumps = 0;
    exp_val = 0; exp_sat = 0;
  endtask

  task automatic bump(inout longint n, inout bit s);
    if (n == MAXV) s = 1'b1;
    else           n = n + 1;
  endtask

  task automatic model_edge();
    longint v;
    bit     s;
    case (sel)
      3'd1: begin v = m_pc;       s = 1'b0;       end
      3'd2: begin v = m_cycles;   s = s_cycles;   end
      3'd3: begin v = m_branches; s = s_branches; end
      3'd4: begin v = m_taken;    s = s_taken;    end
      3'd5: begin v = m_jumps;    s = s_jumps;    end
      3'd6: begin v = m_retired;  s = s_retired;  end
      default: begin v = 0; s = 1'b0; end
    endcase
    if (clear) begin
      model_reset();
    end else begin
      if (!halt) bump(m_cycles, s_cycles);
      if (commit) begin
        bump(m_retired, s_retired);
        m_pc = longint'(pc);
        if (is_cbranch) begin
          bump(m_branches, s_branches);
          if (cbranch_taken) bump(m_taken, s_taken);
        end else if (is_jump) begin
          bump(m_jumps, s_jumps);
        end
      end
    end
    exp_val = v;
    exp_sat = s;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("stat_value", longint'(stat_value), exp_val);
    check("stat_sat", longint'(stat_sat), longint'(exp_sat));
  endtask

  task automatic idle(input bit h);
    clear = 0; halt = h; commit = 0; is_cbranch = 0; cbranch_taken = 0; is_jump = 0;
  endtask

  task automatic retire(input bit br, input bit tk, input bit jp);
    clear = 0; halt = 0; commit = 1; is_cbranch = br; cbranch_taken = tk; is_jump = jp;
    pc = PC_W'($urandom);
    tick();
  endtask

  task automatic do_clear();
    idle(1'b1);
    clear = 1;
    tick();
    clear = 0;
  endtask

  initial begin
    reset = 0; pc = '0; sel = 3'd0;
    idle(1'b0);
    model_reset();
    #1;
    check("reset_value", longint'(stat_value), 0);
    check("reset_sat", longint'(stat_sat), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;

    // Run 100 cycles, then halt for 20: cycle count must freeze at 100.
    sel = 3'b010;
    repeat (100) tick();
    idle(1'b1);
    repeat (20) tick();
    check("halt_freeze", longint'(stat_value), 100);

    // Branch mix: 4 taken, 3 not-taken, 2 jumps, 1 ALU op.
    do_clear();
    repeat (4) retire(1, 1, 0);
    repeat (3) retire(1, 0, 0);
    repeat (2) retire(0, 0, 1);
    retire(0, 0, 0);
    idle(1'b1);
    sel = 3'b011; tick(); check("mix_cbr", longint'(stat_value), 7);
    sel = 3'b100; tick(); check("mix_tkn", longint'(stat_value), 4);
    sel = 3'b101; tick(); check("mix_jmp", longint'(stat_value), 2);
    sel = 3'b110; tick(); check("mix_ins", longint'(stat_value), 10);
    check("mix_sat", longint'(stat_sat), 0);

    // PC capture holds through non-committing cycles.
    clear = 0; halt = 0; commit = 1; is_cbranch = 0; cbranch_taken = 0; is_jump = 0;
    pc = 12'h3A5;
    tick();
    commit = 0; sel = 3'b001;
    for (int i = 0; i < 5; i++) begin
      pc = PC_W'($urandom);
      tick();
    end
    check("pc_capture", longint'(stat_value), 64'h3A5);

    // Clear wins over a same-cycle taken branch.
    clear = 1; halt = 0; commit = 1; is_cbranch = 1; cbranch_taken = 1; is_jump = 0;
    tick();
    idle(1'b1);
    for (int s = 1; s <= 6; s++) begin
      sel = 3'(s);
      tick();
      check("clear_view", longint'(stat_value), 0);
      check("clear_sat", longint'(stat_sat), 0);
    end
    retire(1, 1, 0);
    idle(1'b1);
    sel = 3'b100;
    tick();
    check("post_clear_tkn", longint'(stat_value), 1);

    // Randomized traffic, including simultaneous branch/jump flags and rare clears.
    for (int n = 0; n < 3000; n++) begin
      halt = ($urandom_range(0, 7) == 0);
      commit = halt ? 1'b0 : 1'($urandom);
      is_cbranch = 1'($urandom);
      cbranch_taken = 1'($urandom);
      is_jump = 1'($urandom);
      pc = PC_W'($urandom);
      clear = ($urandom_range(0, 199) == 0);
      sel = 3'($urandom);
      tick();
    end

    // Saturate the cycle counter.
    do_clear();
    idle(1'b0);
    sel = 3'b010;
    repeat (65535 + 3) tick();
    check("sat_value", longint'(stat_value), 64'hFFFF);
    check("sat_flag", longint'(stat_sat), 1);
    sel = 3'b011;
    tick();
    check("sat_other", longint'(stat_sat), 0);

    // Asynchronous reset between edges, then count again from zero.
    do_clear();
    idle(1'b0);
    sel = 3'b010;
    repeat (51) tick();
    check("pre_reset_cyc", longint'(stat_value), 50);
    #1 reset = 0;
    #1;
    check("async_reset_value", longint'(stat_value), 0);
    check("async_reset_sat", longint'(stat_sat), 0);
    model_reset();
    #1 reset = 1;
    repeat (3) tick();
    check("post_reset_cyc", longint'(stat_value), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
